fft_frame_streamer: RTL

FFT_FRAME_STREAMER -- requirements
Module: fft_frame_streamer

---
 rtl/fft_stream_pkg.sv | 30 +++
 rtl/fft_mag_approx.sv | 46 ++++
 rtl/fft_frame_streamer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT frame streamer: input FSM state encoding,
// core lane-packing index helpers and clog2-derived width helpers.
package fft_stream_pkg;

  // Input-side frame FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_LOAD = 2'd2
  } in_state_e;

  // Each complex lane occupies two W-bit fields on the core bus: real, then imaginary.
  localparam int unsigned LANE_FIELDS = 2;

  // Counter/index width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Field index of the real part of a lane on core_x/core_y (X0, X2, ...).
  function automatic int unsigned x_re_idx(input int unsigned lane);
    return LANE_FIELDS * lane;
  endfunction

  // Field index of the imaginary part of a lane on core_x/core_y (X1, X3, ...).
  function automatic int unsigned x_im_idx(input int unsigned lane);
    return LANE_FIELDS * lane + 1;
  endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Single-lane magnitude approximation: max(|re|,|im|) + min(|re|,|im|)/2,
// saturated to the largest positive W-bit value, registered (one cycle).
module fft_mag_approx #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] re,
  input  logic [W-1:0] im,
  output logic [W-1:0] mag
);

  logic [W-1:0] abs_re;
  logic [W-1:0] abs_im;
  logic [W-1:0] mx;
  logic [W-1:0] mn;
  logic [W:0]   sum;
  logic [W:0]   sat_lim;

  // Absolute values (most-negative input maps to 2^(W-1), still fits W bits unsigned) and the sum.
  always_comb begin
    abs_re  = re[W-1] ? (~re + 1'b1) : re;
    abs_im  = im[W-1] ? (~im + 1'b1) : im;
    if (abs_re >= abs_im) begin
      mx = abs_re;
      mn = abs_im;
    end else begin
      mx = abs_im;
      mn = abs_re;
    end
    sum     = {1'b0, mx} + {2'b00, mn[W-1:1]};
    sat_lim = {2'b00, {(W-1){1'b1}}};
  end

  // Register the saturated magnitude.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag <= '0;
    end else if (sum > sat_lim) begin
      mag <= {1'b0, {(W-1){1'b1}}};
    end else begin
      mag <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/fft_frame_streamer.sv
// Streams real-valued sample beats into a streaming FFT core as frames and
// retimes the core's output frames into a valid/bin/last beat stream.
// Optional macro FFT_MAG_EN: output per-lane magnitude instead of raw
// complex bins, adding one cycle of output latency.
module fft_frame_streamer
  import fft_stream_pkg::*;
#(
  parameter int unsigned N     = 1024,
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned GAP   = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*W-1:0]     s_data,
  output logic                   core_next,
  output logic [2*LANES*W-1:0]   core_x,
  input  logic                   core_next_out,
  input  logic [2*LANES*W-1:0]   core_y,
  output logic                   m_valid,
`ifdef FFT_MAG_EN
  output logic [LANES*W-1:0]     m_data,
`else
  output logic [2*LANES*W-1:0]   m_data,
`endif
  output logic [cnt_w(N)-1:0]    m_bin,
  output logic                   m_last,
  input  logic                   clr_err,
  output logic                   underrun,
  output logic                   frame_err
);

  localparam int unsigned B     = N / LANES;
  localparam int unsigned K_W   = cnt_w(B);
  localparam int unsigned BIN_W = cnt_w(N);
  localparam int unsigned GAP_W = cnt_w(GAP + 1);
  localparam int unsigned XW    = LANE_FIELDS * LANES * W;

  // ---------------------------------------------------------------- input side

  in_state_e        state;
  in_state_e        state_nx;
  logic [K_W-1:0]   in_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_ok;
  logic             go;
  logic             beat_last;
  logic [XW-1:0]    core_x_d;

  // Next-state, ready and core input word; the final LOAD beat re-evaluates
  // the IDLE start condition in the same cycle so back-to-back frames run at
  // a 1+B cycle pitch instead of spending an extra cycle in IDLE.
  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    core_x_d  = '0;
    gap_ok    = (gap_cnt >= GAP_W'(GAP));
    go        = s_valid && gap_ok;
    beat_last = (in_cnt == K_W'(B - 1));
    case (state)
      S_IDLE: begin
        if (go) state_nx = S_ARM;
      end
      S_ARM: begin
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            core_x_d[x_re_idx(l)*W +: W] = s_data[l*W +: W];
            core_x_d[x_im_idx(l)*W +: W] = '0;
          end
        end
        if (beat_last) state_nx = go ? S_ARM : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Input FSM state, beat counter and registered core_next/core_x.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_cnt    <= '0;
      core_next <= 1'b0;
      core_x    <= '0;
    end else begin
      state     <= state_nx;
      core_next <= (state_nx == S_ARM);
      core_x    <= core_x_d;
      if ((state == S_LOAD) && !beat_last) begin
        in_cnt <= in_cnt + 1'b1;
      end else begin
        in_cnt <= '0;
      end
    end
  end

  // Cycles elapsed since the last core_next, saturating at GAP (satisfied).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= GAP_W'(GAP);
    end else if (core_next) begin
      gap_cnt <= GAP_W'(1);
    end else if (!gap_ok) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Sticky underrun: a LOAD beat without data; setting wins over clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun <= 1'b0;
    end else if ((state == S_LOAD) && !s_valid) begin
      underrun <= 1'b1;
    end else if (clr_err) begin
      underrun <= 1'b0;
    end
  end

  // --------------------------------------------------------------- output side

  logic             out_active;
  logic [K_W-1:0]   out_k;
  logic             last_d;
  logic [BIN_W-1:0] bin_d;
  logic             v1;
  logic             last1;
  logic [BIN_W-1:0] bin1;
  logic [XW-1:0]    y1;

  // Bin index and last flag for the beat taken this cycle.
  always_comb begin
    last_d = (out_k == K_W'(B - 1));
    bin_d  = BIN_W'(out_k) * BIN_W'(LANES);
  end

  // Output beat counter: core_next_out arms it, beat 0 is the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_active <= 1'b0;
      out_k      <= '0;
    end else if (core_next_out) begin
      out_active <= 1'b1;
      out_k      <= '0;
    end else if (out_active) begin
      if (last_d) begin
        out_active <= 1'b0;
        out_k      <= '0;
      end else begin
        out_k <= out_k + 1'b1;
      end
    end
  end

  // Sticky frame error: a new output frame started inside an active one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
    end else if (core_next_out && out_active) begin
      frame_err <= 1'b1;
    end else if (clr_err) begin
      frame_err <= 1'b0;
    end
  end

  // First output stage: capture the core beat with its bin and last flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      bin1  <= '0;
      y1    <= '0;
    end else begin
      v1    <= out_active;
      last1 <= out_active && last_d;
      bin1  <= out_active ? bin_d : '0;
      y1    <= out_active ? core_y : '0;
    end
  end

`ifdef FFT_MAG_EN
  logic [LANES*W-1:0] mag_bus;
  logic               v2;
  logic               last2;
  logic [BIN_W-1:0]   bin2;

  for (genvar l = 0; l < LANES; l++) begin : g_mag
    fft_mag_approx #(.W(W)) u_mag (
      .clk   (clk),
      .reset (reset),
      .re    (y1[x_re_idx(l)*W +: W]),
      .im    (y1[x_im_idx(l)*W +: W]),
      .mag   (mag_bus[l*W +: W])
    );
  end

  // Second stage: align control with the registered magnitude.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      bin2  <= '0;
    end else begin
      v2    <= v1;
      last2 <= last1;
      bin2  <= bin1;
    end
  end

  assign m_valid = v2;
  assign m_data  = mag_bus;
  assign m_bin   = bin2;
  assign m_last  = last2;
`else
  assign m_valid = v1;
  assign m_data  = y1;
  assign m_bin   = bin1;
  assign m_last  = last1;
`endif

endmodule
